// File: rtl/rom_operand_loader.sv
// rom_operand_loader
// Sequencer that reads one NW-word constant block from a registered-output
// ROM and packs it into a single NW*DW operand for a downstream consumer.
//
// Handshake: op_valid rises when the operand is complete and stays high, with
// op stable, until an edge where op_valid=1 and op_ready=1. That edge
// completes the transfer. op_ready is ignored while op_valid=0. start is
// accepted only while busy=0.
//
// Read timing: the ROM samples rom_a on the edge after CEN is seen low, and
// returns data on rom_q during the following cycle. A pending flag tracks
// every read that the ROM has taken, so the capture happens one edge later.
// The flag is simply the previous cycle's CEN, inverted.

module rom_operand_loader #(
    parameter int AW = 6,
    parameter int DW = 16,
    parameter int NW = 16,
    parameter int SW = 2
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [SW-1:0]    sel,
    output logic             busy,
    output logic             rom_cen,
    output logic [AW-1:0]    rom_a,
    input  logic [DW-1:0]    rom_q,
    output logic [NW*DW-1:0] op,
    output logic             op_valid,
    input  logic             op_ready
);

    localparam int CW = $clog2(NW);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             pend_q,  pend_d;
    logic             busy_q,  busy_d;
    logic             cen_q,   cen_d;
    logic [AW-1:0]    a_q,     a_d;
    logic [NW*DW-1:0] op_q,    op_d;
    logic             valid_q, valid_d;

    // Next-state logic: sequencing, address generation and operand assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        cen_d   = cen_q;
        a_d     = a_q;
        op_d    = op_q;
        valid_d = valid_q;

        // A read was taken by the ROM at this edge if CEN was low before it.
        pend_d  = ~cen_q;

        // Shift each returned word in at the bottom, so offset 0 ends on top.
        if (pend_q && (state_q == S_FETCH || state_q == S_DRAIN)) begin
            op_d = {op_q[NW*DW-DW-1:0], rom_q};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    cen_d   = 1'b0;
                    a_d     = {sel, {CW{1'b0}}};
                end
            end
            S_FETCH: begin
                if (cnt_q == CW'(NW - 1)) begin
                    // Last address already on the bus: stop reading, hold rom_a.
                    cen_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    a_d   = a_q + AW'(1);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                // The final word is captured by the shift above at this edge.
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (valid_q && op_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cen_d   = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset; abort discards pending reads.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            cen_q   <= 1'b1;
            a_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            cen_q   <= cen_d;
            a_q     <= a_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign busy     = busy_q;
    assign rom_cen  = cen_q;
    assign rom_a    = a_q;
    assign op       = op_q;
    assign op_valid = valid_q;

endmodule

// File: tb/tb_rom_operand_loader.sv
// Bench for rom_operand_loader: a behavioural registered-output ROM, directed
// vectors from the ROM reset contents, backpressure / ignored-start / abort
// sequences, and randomized ROM contents checked against a reference model.

module tb_rom_operand_loader;

    logic         CLK = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic         busy;
    logic         rom_cen;
    logic [5:0]   rom_a;
    logic [15:0]  rom_q = 16'h0;
    logic [255:0] op;
    logic         op_valid;
    logic         op_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    rom_operand_loader dut (
        .CLK      (CLK),
        .rst      (rst),
        .start    (start),
        .sel      (sel),
        .busy     (busy),
        .rom_cen  (rom_cen),
        .rom_a    (rom_a),
        .rom_q    (rom_q),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    // Clock / ROM model / monitors
    always #5 CLK = ~CLK;

    logic [15:0] rom_mem [0:63];
    always @(posedge CLK) begin
        if (rom_cen == 1'b0) rom_q <= rom_mem[rom_a];
    end

    logic [5:0] addr_log [$];
    always @(negedge CLK) begin
        if (rom_cen == 1'b0) addr_log.push_back(rom_a);
    end

    int acc_cnt = 0;
    always @(posedge CLK) begin
        if (op_valid === 1'b1 && op_ready === 1'b1) acc_cnt <= acc_cnt + 1;
    end

    typedef struct {
        logic [1:0]   sel;
        logic [255:0] mask;
        logic [255:0] exp;
    } vec_t;

    task automatic rom_init();
        logic [15:0] b3 [0:15];
        b3 = '{16'h2B7E, 16'h1516, 16'h28AE, 16'hD2A6, 16'hABF7, 16'h1588,
               16'h09CF, 16'h4F3C, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
               16'h0005, 16'h0006, 16'hB663, 16'h0007};
        for (int i = 0; i < 64; i++) rom_mem[i] = 16'hFFFF;
        rom_mem[0] = 16'hDCDC; rom_mem[1] = 16'h34B2; rom_mem[2] = 16'h8FAA;
        rom_mem[3] = 16'h0000; rom_mem[4] = 16'hFFFF; rom_mem[5] = 16'h0000;
        rom_mem[16] = 16'h78F6; rom_mem[17] = 16'h1800; rom_mem[18] = 16'h1111;
        rom_mem[19] = 16'h2222; rom_mem[20] = 16'h3333;
        for (int i = 0; i < 16; i++) rom_mem[32 + i] = 16'hA500 + 16'(i);
        for (int i = 0; i < 16; i++) rom_mem[48 + i] = b3[i];
    endtask

    // Reference: word at block offset i sits at bits [255-16i -: 16].
    function automatic logic [255:0] model_op(input logic [1:0] s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[255 - 16 * i -: 16] = rom_mem[int'(s) * 16 + i];
        return r;
    endfunction

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address log must be exactly {s,0}..{s,15}, one per CEN-low cycle.
    task automatic check_addrs(input string name, input logic [1:0] s);
        logic [5:0] exp_q [$];
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(6'(int'(s) * 16 + i));
        n_tests++;
        if (addr_log.size() != exp_q.size()) begin
            bad = 1;
        end else begin
            for (int i = 0; i < 16; i++) if (addr_log[i] !== exp_q[i]) bad = 1;
        end
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d CEN-low cycles starting at %0d, expected 16 starting at %0d",
                     name, addr_log.size(), (addr_log.size() > 0) ? int'(addr_log[0]) : -1,
                     int'(s) * 16);
        end
    endtask

    // Driver: one load, optional backpressure, checks latency and release.
    task automatic run_load(input logic [1:0] s, input int hold, output logic [255:0] got);
        int lat;
        addr_log.delete();
        @(negedge CLK);
        sel      = s;
        start    = 1'b1;
        op_ready = (hold == 0);
        @(negedge CLK);
        start = 1'b0;
        sel   = 2'($urandom_range(0, 3));
        lat   = 0;
        while (op_valid !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check_v("latency", 256'(lat), 256'(17));
        got = op;
        if (hold > 0) begin
            repeat (hold) @(negedge CLK);
            op_ready = 1'b1;
        end
        @(negedge CLK);
        check_v("release", {op_valid, busy, rom_cen}, {1'b0, 1'b0, 1'b1});
        op_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        vec_t vecs [3];
        logic [255:0] got;
        logic [255:0] snap;
        int acc0;
        int seen;

        rom_init();

        // Asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check_v("reset busy", 256'(busy), 256'(0));
        check_v("reset rom_cen", 256'(rom_cen), 256'(1));
        check_v("reset rom_a", 256'(rom_a), 256'(0));
        check_v("reset op", op, 256'(0));
        check_v("reset op_valid", 256'(op_valid), 256'(0));
        @(negedge CLK);
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        check_v("idle after reset", {op, busy, rom_cen, rom_a, op_valid},
                {256'(0), 1'b0, 1'b1, 6'd0, 1'b0});

        // Directed vectors from ROM reset contents
        vecs[0].sel  = 2'd3;
        vecs[0].exp  = {16'h2B7E, 16'h1516, 192'h0, 16'hB663, 16'h0000};
        vecs[0].mask = {32'hFFFF_FFFF, 192'h0, 16'hFFFF, 16'h0000};
        vecs[1].sel  = 2'd0;
        vecs[1].exp  = {80'hDCDC_34B2_8FAA_0000_FFFF, 16'h0000, {10{16'hFFFF}}};
        vecs[1].mask = {256{1'b1}};
        vecs[2].sel  = 2'd1;
        vecs[2].exp  = {80'h78F6_1800_1111_2222_3333, {11{16'hFFFF}}};
        vecs[2].mask = {256{1'b1}};
        for (int i = 0; i < 3; i++) begin
            run_load(vecs[i].sel, 0, got);
            check_v($sformatf("vec%0d op", i), got & vecs[i].mask, vecs[i].exp);
            check_v($sformatf("vec%0d model", i), got, model_op(vecs[i].sel));
            check_addrs($sformatf("vec%0d addrs", i), vecs[i].sel);
        end

        // Backpressure: 10 cycles of op_ready=0, ignored start inside window
        addr_log.delete();
        @(negedge CLK);
        sel = 2'd1; start = 1'b1; op_ready = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        seen = 0;
        while (op_valid !== 1'b1 && seen < 40) begin
            @(negedge CLK);
            seen++;
        end
        check_v("bp latency", 256'(seen), 256'(17));
        snap = op;
        acc0 = acc_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin start = 1'b1; sel = 2'd3; end
            if (k == 5) start = 1'b0;
            @(negedge CLK);
            check_v("bp hold", {op, op_valid, rom_cen, busy}, {snap, 1'b1, 1'b1, 1'b1});
        end
        op_ready = 1'b1;
        @(negedge CLK);
        check_v("bp accept", {op_valid, busy}, {1'b0, 1'b0});
        op_ready = 1'b0;
        repeat (20) @(negedge CLK);
        check_v("bp one accept", 256'(acc_cnt - acc0), 256'(1));
        check_addrs("bp addrs", 2'd1);
        check_v("bp op", snap, model_op(2'd1));

        // Starts during FETCH and in the acceptance cycle are ignored
        addr_log.delete();
        acc0 = acc_cnt;
        @(negedge CLK);
        sel = 2'd2; start = 1'b1; op_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        start = 1'b1; sel = 2'd1;
        @(negedge CLK);
        start = 1'b0; sel = 2'd3;
        seen = 0;
        while (op_valid !== 1'b1 && seen < 40) begin
            @(negedge CLK);
            seen++;
        end
        snap = op;
        start = 1'b1; sel = 2'd0;
        @(negedge CLK);
        start = 1'b0;
        repeat (25) @(negedge CLK);
        check_addrs("ign addrs", 2'd2);
        check_v("ign one operand", 256'(acc_cnt - acc0), 256'(1));
        check_v("ign op", snap, model_op(2'd2));
        check_v("ign idle", {busy, op_valid}, {1'b0, 1'b0});

        // Randomized ROM contents against the reference model
        for (int t = 0; t < 8; t++) begin
            logic [1:0] s;
            for (int i = 0; i < 64; i++) rom_mem[i] = 16'($urandom);
            s = 2'($urandom_range(0, 3));
            run_load(s, $urandom_range(0, 4), got);
            check_v($sformatf("rand%0d op", t), got, model_op(s));
            check_addrs($sformatf("rand%0d addrs", t), s);
        end
        rom_init();

        // Abort at E8 of a sel=2 load
        addr_log.delete();
        @(negedge CLK);
        sel = 2'd2; start = 1'b1; op_ready = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #2 rst = 1'b1;
        #1;
        check_v("abort reset", {op, busy, rom_cen, rom_a, op_valid},
                {256'(0), 1'b0, 1'b1, 6'd0, 1'b0});
        @(negedge CLK);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(negedge CLK);
            if (op_valid === 1'b1) seen = 1;
        end
        check_v("abort no valid", 256'(seen), 256'(0));
        check_v("abort cen cycles", 256'(addr_log.size()), 256'(8));
        run_load(2'd0, 0, got);
        check_v("after abort top", 256'(got[255:240]), 256'(16'hDCDC));
        check_v("after abort op", got, model_op(2'd0));
        check_addrs("after abort addrs", 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
